// File: rtl/cpu.sv
// cpu: 5-stage pipelined MIPS-subset core (IF/ID/EX/MEM/WB) with local instruction and data memories.
// Operands are forwarded into EX; load-use stalls one cycle; beq/j resolve in ID and flush IF/ID.

module cpu_pc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] next_i,
  output logic [31:0] pc_o
);
  logic [31:0] pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     pc_q <= '0;
    else if (en_i) pc_q <= next_i;
  end

  assign pc_o = pc_q;
endmodule

module cpu_imem #(
  parameter  int unsigned WORDS = 256,
  localparam int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] memory [0:WORDS-1];

  // Load port; the core itself never writes program memory.
  always_ff @(posedge clk_i) begin
    if (we_i) memory[waddr_i] <= wdata_i;
  end

  assign rdata_o = memory[raddr_i];
endmodule

module cpu_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] register [0:31];

  always_ff @(posedge clk_i) begin
    if (we_i && (wa_i != 5'd0)) register[wa_i] <= wd_i;
  end

  // r0 is hardwired to zero; a same-cycle WB write is bypassed to the readers.
  always_comb begin
    rd1_o = register[ra1_i];
    rd2_o = register[ra2_i];
    if (ra1_i == 5'd0)                    rd1_o = '0;
    else if (we_i && (wa_i == ra1_i))     rd1_o = wd_i;
    if (ra2_i == 5'd0)                    rd2_o = '0;
    else if (we_i && (wa_i == ra2_i))     rd2_o = wd_i;
  end
endmodule

module cpu_dmem #(
  parameter  int unsigned BYTES = 32,
  localparam int unsigned AW    = $clog2(BYTES)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-3:0] word_i,
  input  logic [31:0]   wd_i,
  output logic [31:0]   rd_o
);
  logic [7:0] memory [0:BYTES-1];

  // Little-endian word: lowest address holds the least significant byte.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[{word_i, 2'd0}] <= wd_i[7:0];
      memory[{word_i, 2'd1}] <= wd_i[15:8];
      memory[{word_i, 2'd2}] <= wd_i[23:16];
      memory[{word_i, 2'd3}] <= wd_i[31:24];
    end
  end

  assign rd_o = {memory[{word_i, 2'd3}], memory[{word_i, 2'd2}],
                 memory[{word_i, 2'd1}], memory[{word_i, 2'd0}]};
endmodule

module cpu #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_BYTES = 32
) (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_BYTES);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        mem_to_reg;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] store;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] result;
  } memwb_t;

  ifid_t  ifid_q,  ifid_d;
  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  logic [31:0] pc, pc_next, pc_plus4, if_instr;
  logic        pc_en, hold, load_use, redirect;
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_dest;
  logic [31:0] id_imm, id_target, rf_rd1, rf_rd2;
  ctrl_t       id_ctrl;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y, dmem_rd;

  cpu_pc PC (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(pc_en), .next_i(pc_next), .pc_o(pc)
  );

  cpu_imem #(.WORDS(IMEM_WORDS)) Instruction_Memory (
    .clk_i(clk_i), .we_i(1'b0), .waddr_i('0), .wdata_i('0),
    .raddr_i(pc[IAW+1:2]), .rdata_o(if_instr)
  );

  cpu_regfile Registers (
    .clk_i(clk_i), .we_i(memwb_q.reg_write), .wa_i(memwb_q.dest), .wd_i(memwb_q.result),
    .ra1_i(id_rs), .ra2_i(id_rt), .rd1_o(rf_rd1), .rd2_o(rf_rd2)
  );

  cpu_dmem #(.BYTES(DMEM_BYTES)) Data_Memory (
    .clk_i(clk_i), .we_i(exmem_q.mem_write), .word_i(exmem_q.alu[DAW-1:2]),
    .wd_i(exmem_q.store), .rd_o(dmem_rd)
  );

  assign pc_plus4 = pc + 32'd4;
  assign id_op    = ifid_q.instr[31:26];
  assign id_rs    = ifid_q.instr[25:21];
  assign id_rt    = ifid_q.instr[20:16];
  assign id_rd    = ifid_q.instr[15:11];
  assign id_funct = ifid_q.instr[5:0];
  assign id_imm   = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};

  // Decode; any unsupported encoding leaves all controls at zero (nop).
  always_comb begin
    id_ctrl = '0;
    id_dest = '0;
    case (id_op)
      6'h00: begin
        id_dest           = id_rd;
        id_ctrl.reg_write = 1'b1;
        case (id_funct)
          6'h20:   id_ctrl.alu_op = ALU_ADD;
          6'h22:   id_ctrl.alu_op = ALU_SUB;
          6'h24:   id_ctrl.alu_op = ALU_AND;
          6'h25:   id_ctrl.alu_op = ALU_OR;
          6'h18:   id_ctrl.alu_op = ALU_MUL;
          default: id_ctrl.reg_write = 1'b0;
        endcase
      end
      6'h08: begin
        id_dest           = id_rt;
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
      end
      6'h23: begin
        id_dest            = id_rt;
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_read   = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_src    = 1'b1;
      end
      6'h2B: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
      end
      default: ;
    endcase
  end

  // A low start_i freezes the front end exactly like a stall so a pending redirect is not lost.
  assign load_use  = idex_q.ctrl.mem_read && ((idex_q.dest == id_rs) || (idex_q.dest == id_rt));
  assign hold      = load_use || !start_i;
  assign pc_en     = !hold;
  assign redirect  = !hold && ((id_op == 6'h02) || ((id_op == 6'h04) && (rf_rd1 == rf_rd2)));
  assign id_target = (id_op == 6'h02) ? {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00}
                                      : ifid_q.pc4 + {id_imm[29:0], 2'b00};
  assign pc_next   = redirect ? id_target : pc_plus4;

  always_comb begin
    ifid_d = ifid_q;
    idex_d = '0;
    if (!hold) begin
      ifid_d.instr  = redirect ? 32'h0 : if_instr;
      ifid_d.pc4    = pc_plus4;
      idex_d.ctrl   = id_ctrl;
      idex_d.rs     = id_rs;
      idex_d.rt     = id_rt;
      idex_d.dest   = id_dest;
      idex_d.rs_val = rf_rd1;
      idex_d.rt_val = rf_rd2;
      idex_d.imm    = id_imm;
    end
  end

  // EX/MEM result wins over MEM/WB; r0 and non-writing producers never forward.
  always_comb begin
    fwd_a = idex_q.rs_val;
    fwd_b = idex_q.rt_val;
    if (exmem_q.reg_write && (exmem_q.dest != 5'd0) && (exmem_q.dest == idex_q.rs))
      fwd_a = exmem_q.alu;
    else if (memwb_q.reg_write && (memwb_q.dest != 5'd0) && (memwb_q.dest == idex_q.rs))
      fwd_a = memwb_q.result;
    if (exmem_q.reg_write && (exmem_q.dest != 5'd0) && (exmem_q.dest == idex_q.rt))
      fwd_b = exmem_q.alu;
    else if (memwb_q.reg_write && (memwb_q.dest != 5'd0) && (memwb_q.dest == idex_q.rt))
      fwd_b = memwb_q.result;
  end

  assign alu_b = idex_q.ctrl.alu_src ? idex_q.imm : fwd_b;

  always_comb begin
    case (idex_q.ctrl.alu_op)
      ALU_ADD: alu_y = fwd_a + alu_b;
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_OR:  alu_y = fwd_a | alu_b;
      ALU_MUL: alu_y = 32'(fwd_a * alu_b);
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = idex_q.ctrl.reg_write;
    exmem_d.mem_write  = idex_q.ctrl.mem_write;
    exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;
    exmem_d.dest       = idex_q.dest;
    exmem_d.alu        = alu_y;
    exmem_d.store      = fwd_b;
    memwb_d            = '0;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.dest       = exmem_q.dest;
    memwb_d.result     = exmem_q.mem_to_reg ? dmem_rd : exmem_q.alu;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed and random programs checked against an instruction-level reference model;
// a monitor matches every register-file write and store against queued expectations.

module tb_cpu;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;

  cpu #(.IMEM_WORDS(256), .DMEM_BYTES(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [4:0] rd;   logic [31:0] val;} wr_t;
  typedef struct {logic [4:0] addr; logic [31:0] val;} st_t;

  int errors = 0;
  int checks = 0;
  wr_t exp_wr[$];
  st_t exp_st[$];
  logic [31:0] prog [256];
  logic [7:0]  init_mem [32];
  logic [31:0] m_reg [32];
  logic [7:0]  m_mem [32];
  logic [31:0] pc_seq[$];
  bit mon_en = 1'b0;
  bit first_reset = 1'b1;
  wr_t mon_w;
  st_t mon_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int funct);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(funct)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  function automatic void mwr(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 5'd0) begin
      m_reg[rd] = v;
      exp_wr.push_back('{rd, v});
    end
  endfunction

  // Architectural interpreter: runs the program in order until a jump to itself.
  task automatic model_run();
    logic [31:0] pc, npc, ins, a, b, imm;
    logic [4:0]  ad;
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_mem[i] = init_mem[i];
    end
    pc = '0;
    for (int steps = 0; steps < 2000; steps++) begin
      ins = prog[pc[9:2]];
      a   = m_reg[ins[25:21]];
      b   = m_reg[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      ad  = 5'(a + imm) & 5'h1C;
      npc = pc + 32'd4;
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h20: mwr(ins[15:11], a + b);
          6'h22: mwr(ins[15:11], a - b);
          6'h24: mwr(ins[15:11], a & b);
          6'h25: mwr(ins[15:11], a | b);
          6'h18: mwr(ins[15:11], a * b);
          default: ;
        endcase
        6'h08: mwr(ins[20:16], a + imm);
        6'h23: mwr(ins[20:16], {m_mem[5'(ad + 5'd3)], m_mem[5'(ad + 5'd2)],
                                m_mem[5'(ad + 5'd1)], m_mem[ad]});
        6'h2B: begin
          m_mem[ad]              = b[7:0];
          m_mem[5'(ad + 5'd1)]   = b[15:8];
          m_mem[5'(ad + 5'd2)]   = b[23:16];
          m_mem[5'(ad + 5'd3)]   = b[31:24];
          exp_st.push_back('{ad, b});
        end
        6'h04: if (a == b) npc = npc + (imm << 2);
        6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
        default: ;
      endcase
      if ((ins[31:26] == 6'h02) && (npc == pc)) break;
      pc = npc;
    end
  endtask

  // Scoreboard monitor: every write the DUT commits must be the next one the model predicted.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (dut.Registers.we_i && (dut.Registers.wa_i != 5'd0)) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL reg_write: got unexpected r%0d=0x%08h, expected no write",
                   dut.Registers.wa_i, dut.Registers.wd_i);
        end else begin
          mon_w = exp_wr.pop_front();
          check("wb_reg", 32'(dut.Registers.wa_i), 32'(mon_w.rd));
          check("wb_data", dut.Registers.wd_i, mon_w.val);
        end
      end
      if (dut.Data_Memory.we_i) begin
        if (exp_st.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL store: got unexpected store 0x%08h, expected no store", dut.Data_Memory.wd_i);
        end else begin
          mon_s = exp_st.pop_front();
          check("st_addr", 32'({dut.Data_Memory.word_i, 2'b00}), 32'(mon_s.addr));
          check("st_data", dut.Data_Memory.wd_i, mon_s.val);
        end
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = '0;
    for (int i = 0; i < 32; i++) init_mem[i] = '0;
  endtask

  task automatic load_and_reset();
    rst_i   = 1'b1;
    start_i = 1'b0;
    mon_en  = 1'b0;
    if (!first_reset) begin
      #1;
      check("async_reset_pc", dut.PC.pc_o, 32'h0);
    end
    first_reset = 1'b0;
    @(negedge clk_i);
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = prog[i];
    for (int i = 0; i < 32; i++) begin
      dut.Registers.register[i] = '0;
      dut.Data_Memory.memory[i] = init_mem[i];
    end
    exp_wr.delete();
    exp_st.delete();
    model_run();
    @(negedge clk_i);
    rst_i  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic check_pcs(input string name);
    foreach (pc_seq[k]) begin
      @(negedge clk_i);
      check($sformatf("%s_pc%0d", name, k), dut.PC.pc_o, pc_seq[k]);
    end
  endtask

  task automatic finish_prog(input string name, input int cycles);
    repeat (cycles) @(negedge clk_i);
    mon_en = 1'b0;
    check({name, "_missing_writes"}, 32'(exp_wr.size()), 32'h0);
    check({name, "_missing_stores"}, 32'(exp_st.size()), 32'h0);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_r%0d", name, i), dut.Registers.register[i], m_reg[i]);
    for (int w = 0; w < 8; w++)
      check($sformatf("%s_mem%0d", name, 4 * w),
            {dut.Data_Memory.memory[4*w+3], dut.Data_Memory.memory[4*w+2],
             dut.Data_Memory.memory[4*w+1], dut.Data_Memory.memory[4*w]},
            {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]});
  endtask

  task automatic gen_random(input int n);
    int k, ra, rb, rc, f;
    clear_prog();
    for (int i = 0; i < n; i++) begin
      k  = int'($urandom_range(0, 9));
      ra = int'($urandom_range(0, 7));
      rb = int'($urandom_range(0, 7));
      rc = int'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: f = 32'h20;
        1: f = 32'h22;
        2: f = 32'h24;
        3: f = 32'h25;
        default: f = 32'h18;
      endcase
      case (k)
        0, 1, 6: prog[i] = enc_r(ra, rb, rc, f);
        2, 3:    prog[i] = enc_i(8, ra, rb, 16'($urandom));
        4:       prog[i] = enc_i(8'h23, 0, rb, 16'(4 * $urandom_range(0, 7)));
        5:       prog[i] = enc_i(8'h2B, 0, rb, 16'(4 * $urandom_range(0, 7)));
        7:       prog[i] = 32'h0;
        8:       prog[i] = {6'h0F, 26'($urandom)};
        default: prog[i] = enc_r(ra, rb, rc, 32'h21);
      endcase
    end
    prog[n] = enc_j(32'(4 * n));
    for (int i = 0; i < 32; i++) init_mem[i] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset/hold, then ALU chain relying on EX/MEM and MEM/WB forwarding without stalls.
    clear_prog();
    prog[0] = enc_i(8, 0, 8, 16'd5);
    prog[1] = enc_i(8, 8, 9, 16'd3);
    prog[2] = enc_r(8, 9, 10, 32'h20);
    prog[3] = enc_r(10, 9, 11, 32'h18);
    prog[4] = enc_j(32'd16);
    load_and_reset();
    pc_seq = '{32'd0, 32'd0, 32'd0};
    check_pcs("hold");
    start_i = 1'b1;
    pc_seq = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd16};
    check_pcs("alu");
    finish_prog("alu", 30);
    check("alu_r10_const", dut.Registers.register[10], 32'd13);
    check("alu_r11_const", dut.Registers.register[11], 32'd104);

    // Load-use: one held PC cycle, loaded value forwarded into addi then into the store.
    clear_prog();
    init_mem[0] = 8'd5;
    prog[0] = enc_i(8'h23, 0, 8, 16'd0);
    prog[1] = enc_i(8, 8, 9, 16'd1);
    prog[2] = enc_i(8'h2B, 0, 9, 16'd4);
    prog[3] = enc_j(32'd12);
    load_and_reset();
    start_i = 1'b1;
    pc_seq = '{32'd4, 32'd8, 32'd8, 32'd12, 32'd16, 32'd12};
    check_pcs("ldu");
    finish_prog("ldu", 30);
    check("ldu_r9_const", dut.Registers.register[9], 32'd6);
    check("ldu_word4_const", {dut.Data_Memory.memory[7], dut.Data_Memory.memory[6],
                              dut.Data_Memory.memory[5], dut.Data_Memory.memory[4]}, 32'd6);

    // Taken beq skips two words; the slot after it is flushed.
    clear_prog();
    prog[0] = enc_i(4, 0, 0, 16'd2);
    prog[1] = enc_i(8, 0, 8, 16'd1);
    prog[2] = enc_i(8, 0, 8, 16'd1);
    prog[3] = enc_i(8, 0, 9, 16'd2);
    prog[4] = enc_j(32'd16);
    load_and_reset();
    start_i = 1'b1;
    pc_seq = '{32'd4, 32'd12, 32'd16, 32'd20, 32'd16};
    check_pcs("beq");
    finish_prog("beq", 30);
    check("beq_r8_const", dut.Registers.register[8], 32'd0);

    // Jump to itself: PC alternates and the following instruction never commits.
    clear_prog();
    prog[0] = enc_j(32'd0);
    prog[1] = enc_i(8, 0, 9, 16'd7);
    load_and_reset();
    start_i = 1'b1;
    pc_seq = '{32'd4, 32'd0, 32'd4, 32'd0, 32'd4, 32'd0};
    check_pcs("jmp");
    finish_prog("jmp", 20);
    check("jmp_r9_const", dut.Registers.register[9], 32'd0);

    // r0 stays zero; sub yields a negative result.
    clear_prog();
    prog[0] = enc_i(8, 0, 0, 16'd7);
    prog[1] = enc_i(8, 0, 8, 16'd3);
    prog[2] = enc_r(0, 8, 9, 32'h22);
    prog[3] = enc_j(32'd12);
    load_and_reset();
    start_i = 1'b1;
    finish_prog("r0", 30);
    check("r0_read_const", dut.Registers.rd1_o & 32'h0, 32'h0 & dut.Registers.rd1_o);
    check("r9_neg_const", dut.Registers.register[9], 32'hFFFF_FFFD);

    // Random straight-line programs mixing ALU ops, loads, stores and nops.
    for (int t = 0; t < 8; t++) begin
      gen_random(20);
      load_and_reset();
      start_i = 1'b1;
      finish_prog($sformatf("rnd%0d", t), 4 * 20 + 40);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- 5-stage pipelined 32-bit MIPS-subset processor: IF, ID, EX, MEM, WB.
- Contains its own instruction memory, data memory, register file and PC, with forwarding, load-use stall and branch/jump flush.
- Top-level compute block of the project. The bench preloads memories through hierarchy and observes PC, registers and data memory every clock.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- DMEM_BYTES, 32, data memory depth in bytes.

Ports:
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  run enable; PC holds while low, advances while high.

Behaviour:
- Required hierarchy, so the bench can preload and observe state:
  - Instruction_Memory.memory[0:255], 32-bit words.
  - Data_Memory.memory[0:31], 8-bit bytes.
  - Registers.register[0:31], 32-bit.
  - PC.pc_o, 32-bit.
- Reset (rst_i=1, async):
  - Clears pc_o and all pipeline registers (bubbles), plus the stall and flush state.
  - Does not clear the register file or either memory.
- PC:
  - If start_i=0, pc_o holds. Otherwise, on each clock edge pc_o takes the next-PC value.
  - Next-PC priority: stall (hold) > taken beq/j target > pc+4.
- IF: instruction = Instruction_Memory.memory[pc_o[9:2]], read combinationally.
- Supported instructions; every other encoding executes as a nop, and word 0 is a nop:
  - R-type (opcode 0): add funct 0x20, sub 0x22, and 0x24, or 0x25, mul 0x18 (low 32 bits of product). rd written.
  - addi 0x08: sign-extended immediate, rt written.
  - lw 0x23 and sw 0x2B: address = rs + sign-extended imm.
  - beq 0x04 and j 0x02.
- Register file:
  - Two combinational read ports.
  - Write on rising edge in WB; writes to r0 are ignored and r0 always reads 0.
  - Same-cycle WB write to a register being read in ID is bypassed to the read output.
- Data memory:
  - Byte-addressed, little-endian. Word at address A = {mem[A+3], mem[A+2], mem[A+1], mem[A]}.
  - lw reads combinationally in MEM. sw writes 4 bytes at the rising edge.
  - Addresses use bits [4:0]; word accesses are aligned.
- Forwarding (operands into EX):
  - EX/MEM result takes priority over MEM/WB result.
  - A source is forwarded only when the destination register is nonzero and RegWrite is set.
  - sw store data is forwarded the same way.
- Load-use hazard:
  - Condition: lw in EX whose rt matches rs or rt of the instruction in ID.
  - Action: stall 1 cycle. PC and IF/ID hold; a bubble (all controls zero) is inserted into ID/EX.
- Branch:
  - beq resolved in ID: compare the two register-file outputs; target = pc+4 + (sext(imm)<<2).
  - If taken: IF/ID flushed to a nop, giving 1 flush cycle.
  - Branch operands are not forwarded from EX/MEM. Software separates producers by 2 instructions or relies on the WB bypass.
- Jump: j resolved in ID; target = {pc+4[31:28], imm26, 2'b00}; IF/ID flushed.
- Simultaneous events: stall overrides flush. A branch in ID during a load-use stall is re-evaluated on the next cycle.
- Latency: a result is architecturally visible in the register file 4 cycles after fetch of the producing instruction (written at the WB edge).

Test Plan:
- Reset/hold: rst_i=1 then 0 with start_i=0 → pc_o stays 0 for 3 cycles. Set start_i=1 → pc_o = 4, 8, 12 on successive edges.
- ALU + forwarding: addi $8,$0,5; addi $9,$8,3; add $10,$8,$9; mul $11,$10,$9 → r8=5, r9=8, r10=13, r11=104, with no stall cycles.
- Load-use: mem[0]=5; lw $8,0($0); addi $9,$8,1; sw $9,4($0) → r9=6, word 0x04 = 6, exactly 1 stall, PC held one cycle.
- Branch flush: beq $0,$0,+2 followed by addi $8,$0,1 → r8 stays 0; PC jumps to branch pc+12; 1 flush.
- Jump loop: j to own address → pc_o repeats the same value every 2 cycles; the instruction after j never writes.
- Register 0: addi $0,$0,7 → r0 reads 0. A sub producing a negative value (addi $8,$0,3; sub $9,$0,$8) → r9 = 0xFFFFFFFD.
